cla_pipe_addsub: RTL and testbench



---
 rtl/cla_pipe_addsub.sv | 172 +++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
// The operands are split into STAGES segments of SEG = WIDTH/STAGES bits.
// Stage k adds segment k using 4-bit lookahead groups, with lookahead across
// the groups, and passes its carry to stage k+1. A valid/ready handshake
// accepts one operation per cycle, and each result appears STAGES cycles
// after its operands are accepted.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready = !out_valid || out_ready)
//   x, y, cin, sub       operands; sub=1 computes x + ~y + cin
//   out_valid / out_ready  result handshake
//   sum, cout, ovf, zero   registered result and status flags
module cla_pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG = WIDTH / STAGES;
  localparam int unsigned NG  = SEG / 4;

  // Returns all the carries of one segment. Bit c[i] is the carry into bit i,
  // and c[SEG] is the carry out of the segment.
  function automatic logic [SEG:0] cla_carries(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic           c0);
    logic [SEG-1:0] g, p;
    logic [NG-1:0]  gg, gp;
    logic [NG:0]    gc;
    logic [SEG:0]   c;
    logic           t;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < int'(NG); j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Each group carry is a flat sum of products of the lower groups' G/P terms.
    for (int j = 0; j <= int'(NG); j++) begin
      gc[j] = c0;
      for (int m = 0; m < j; m++) gc[j] = gc[j] & gp[m];
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        gc[j] = gc[j] | t;
      end
    end
    // Carries inside each group are expanded from the group's carry-in.
    for (int j = 0; j < int'(NG); j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    c[SEG] = gc[NG];
    return c;
  endfunction

  logic             adv_c;
  logic [WIDTH-1:0] yin_c;

  // The whole pipeline advances together, or it holds as a whole.
  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;
  assign yin_c    = sub ? ~y : y;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stg
    localparam int unsigned SW = (k + 1) * SEG;

    logic [SEG-1:0] a_c, b_c, ss_c;
    logic           ci_c, vi_c;
    logic [SEG:0]   cy_c;
    logic [SW-1:0]  sn_c;
    logic           v_q;
    logic [SW-1:0]  s_q;

    // Stage inputs: the accepted operands, or the predecessor stage's skew registers.
    if (k == 0) begin : g_src
      assign a_c  = x[SEG-1:0];
      assign b_c  = yin_c[SEG-1:0];
      assign ci_c = cin;
      assign vi_c = in_valid;
      assign sn_c = ss_c;
    end else begin : g_src
      assign a_c  = g_stg[k-1].g_mid.xr_q[SEG-1:0];
      assign b_c  = g_stg[k-1].g_mid.yr_q[SEG-1:0];
      assign ci_c = g_stg[k-1].g_mid.c_q;
      assign vi_c = g_stg[k-1].v_q;
      assign sn_c = {ss_c, g_stg[k-1].s_q};
    end

    assign cy_c = cla_carries(a_c, b_c, ci_c);
    assign ss_c = a_c ^ b_c ^ cy_c[SEG-1:0];

    // Valid bit and the sum bits computed so far.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (adv_c) begin
        v_q <= vi_c;
        s_q <= sn_c;
      end
    end

    if (k < int'(STAGES) - 1) begin : g_mid
      localparam int unsigned RW = WIDTH - SW;
      logic [RW-1:0] xn_c, yn_c, xr_q, yr_q;
      logic          c_q;

      // Upper operand segments that later stages have not consumed yet.
      if (k == 0) begin : g_skew
        assign xn_c = x[WIDTH-1:SEG];
        assign yn_c = yin_c[WIDTH-1:SEG];
      end else begin : g_skew
        assign xn_c = g_stg[k-1].g_mid.xr_q[WIDTH-k*SEG-1:SEG];
        assign yn_c = g_stg[k-1].g_mid.yr_q[WIDTH-k*SEG-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          xr_q <= '0;
          yr_q <= '0;
          c_q  <= 1'b0;
        end else if (adv_c) begin
          xr_q <= xn_c;
          yr_q <= yn_c;
          c_q  <= cy_c[SEG];
        end
      end
    end else begin : g_last
      logic cout_q, ovf_q, zero_q;

      // Flags come from the MSB carries and the full sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv_c) begin
          cout_q <= cy_c[SEG];
          ovf_q  <= cy_c[SEG] ^ cy_c[SEG-1];
          zero_q <= ~|sn_c;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign cout      = g_stg[STAGES-1].g_last.cout_q;
  assign ovf       = g_stg[STAGES-1].g_last.ovf_q;
  assign zero      = g_stg[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub. The directed cases run on a 32-bit, 4-stage
// instance. Random traffic runs on the (32,1), (32,8), (16,2) and (64,4)
// instances, and every result is checked against plain wide arithmetic.
module tb_cla_pipe_addsub;

  localparam int unsigned NOPS = 10000;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic [31:0] t;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] cyc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: (w+1)-bit integer sum; overflow means equal operand signs and a differing result sign.
  function automatic exp_t ref_op(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                  input logic ci, input logic su);
    exp_t        r;
    logic [64:0] full;
    logic [63:0] mask, aa, bb;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a & mask;
    bb   = (su ? ~b : b) & mask;
    full = {1'b0, aa} + {1'b0, bb} + 65'(ci);
    r.s  = full[63:0] & mask;
    r.co = full[w];
    r.ov = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
    r.z  = (r.s == 64'd0);
    r.t  = '0;
    return r;
  endfunction

  // ---------------- directed instance (32,4) ----------------
  logic        m_rst, m_iv, m_ir, m_ov, m_ordy, m_cin, m_sub, m_co, m_of, m_zr;
  logic [31:0] m_x, m_y, m_sum;
  exp_t        mq[$];
  logic        lat_on = 1'b0;

  cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(m_rst), .in_valid(m_iv), .in_ready(m_ir), .x(m_x), .y(m_y),
    .cin(m_cin), .sub(m_sub), .out_valid(m_ov), .out_ready(m_ordy), .sum(m_sum),
    .cout(m_co), .ovf(m_of), .zero(m_zr)
  );

  // One cycle: drive inputs at the falling edge, then score what the next rising edge transfers.
  task automatic step(input logic iv, input logic ordy, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic su);
    exp_t e;
    @(negedge clk);
    m_iv = iv; m_ordy = ordy; m_x = a; m_y = b; m_cin = ci; m_sub = su;
    #1;
    if (m_ov && m_ordy) begin
      if (mq.size() == 0) chk("m_spurious", 64'(m_ov), 64'd0);
      else begin
        e = mq.pop_front();
        chk("m_sum", 64'(m_sum), e.s);
        chk("m_flags", 64'({m_co, m_of, m_zr}), 64'({e.co, e.ov, e.z}));
        if (lat_on) chk("m_latency", 64'(cyc - e.t), 64'd4);
      end
    end
    if (m_iv && m_ir) begin
      e   = ref_op(32, 64'(a), 64'(b), ci, su);
      e.t = cyc;
      mq.push_back(e);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic su);
    step(1'b1, 1'b1, a, b, ci, su);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mq.size() != 0; i++) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    chk("m_drain_left", 64'(mq.size()), 64'd0);
  endtask

  task automatic chk_cleared(input string tag);
    chk(tag, 64'({m_ov, m_co, m_of, m_zr}), 64'd0);
    chk({tag, "_sum"}, 64'(m_sum), 64'd0);
  endtask

  // ---------------- random sweep instances ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int unsigned W = (gi == 2) ? 16 : (gi == 3) ? 64 : 32;
    localparam int unsigned S = (gi == 0) ? 1 : (gi == 1) ? 8 : (gi == 2) ? 2 : 4;
    logic         rs, iv, ir, ov, ordy, ci, su, co, of, zr;
    logic [W-1:0] xa, yb, sm;
    logic         done = 1'b0;
    exp_t         q[$];

    cla_pipe_addsub #(.WIDTH(W), .STAGES(S)) u_sw (
      .clk(clk), .rst(rs), .in_valid(iv), .in_ready(ir), .x(xa), .y(yb),
      .cin(ci), .sub(su), .out_valid(ov), .out_ready(ordy), .sum(sm),
      .cout(co), .ovf(of), .zero(zr)
    );

    initial begin
      int unsigned issued = 0, got = 0, cycles = 0;
      exp_t        e;
      logic [63:0] ra, rb;
      rs = 1'b1; iv = 1'b0; ordy = 1'b0; xa = '0; yb = '0; ci = 1'b0; su = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rs = 1'b0;
      while (got < NOPS && cycles < 60000) begin
        @(negedge clk);
        cycles++;
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        case ($urandom_range(0, 7))
          0: rb = ra;
          1: rb = '1;
          2: ra = '1;
          3: rb = 64'd1;
          default: ;
        endcase
        iv   = (issued < NOPS) && ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        xa   = W'(ra);
        yb   = W'(rb);
        ci   = 1'($urandom);
        su   = 1'($urandom);
        #1;
        if (ov && ordy) begin
          if (q.size() == 0) chk($sformatf("sw%0d_spurious", gi), 64'(ov), 64'd0);
          else begin
            e = q.pop_front();
            chk($sformatf("sw%0d_sum", gi), 64'(sm), e.s);
            chk($sformatf("sw%0d_flags", gi), 64'({co, of, zr}), 64'({e.co, e.ov, e.z}));
            got++;
          end
        end
        if (iv && ir) begin
          q.push_back(ref_op(W, 64'(xa), 64'(yb), ci, su));
          issued++;
        end
      end
      chk($sformatf("sw%0d_completed", gi), 64'(got), 64'(NOPS));
      done = 1'b1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_rst = 1'b1; m_iv = 1'b0; m_ordy = 1'b0; m_x = '0; m_y = '0; m_cin = 1'b0; m_sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_rst = 1'b0;
    #1;
    chk_cleared("rst_state");
    chk("rst_in_ready_idle", 64'(m_ir), 64'd1);

    // Back-to-back basic adds, carries across segments, and subtracts.
    lat_on = 1'b1;
    issue(32'd1, 32'd2, 1'b0, 1'b0);
    issue(32'd1, 32'd2, 1'b1, 1'b0);
    issue(32'd5, 32'd16, 1'b0, 1'b0);
    issue(32'd12, 32'd18, 1'b1, 1'b0);
    issue(32'h0000FFFF, 32'd1, 1'b0, 1'b0);
    issue(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    issue(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
    issue(32'd5, 32'd16, 1'b1, 1'b1);
    issue(32'd16, 32'd5, 1'b1, 1'b1);
    issue(32'h80000000, 32'd1, 1'b1, 1'b1);
    issue(32'd7, 32'd7, 1'b1, 1'b1);
    drain();
    lat_on = 1'b0;

    // Fill the pipe with four operations, then stall the consumer for three cycles.
    issue(32'h11111111, 32'h01010101, 1'b0, 1'b0);
    issue(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0);
    issue(32'h00000100, 32'h00000001, 1'b1, 1'b1);
    issue(32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
      chk("stall_in_ready", 64'(m_ir), 64'd0);
      chk("stall_valid", 64'(m_ov), 64'd1);
      chk("stall_sum", 64'(m_sum), mq[0].s);
      chk("stall_flags", 64'({m_co, m_of, m_zr}), 64'({mq[0].co, mq[0].ov, mq[0].z}));
    end
    drain();

    // Reset with three operations in flight; an input transfer offered at the same edge must be dropped.
    issue(32'd100, 32'd200, 1'b0, 1'b0);
    issue(32'd300, 32'd400, 1'b0, 1'b0);
    issue(32'd500, 32'd600, 1'b0, 1'b0);
    @(negedge clk);
    m_rst = 1'b1; m_iv = 1'b1; m_ordy = 1'b1; m_x = 32'd9; m_y = 32'd9;
    @(negedge clk);
    m_rst = 1'b0; m_iv = 1'b0;
    mq.delete();
    #1;
    chk_cleared("midrst_state");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    lat_on = 1'b1;
    issue(32'd2, 32'd3, 1'b0, 1'b0);
    drain();
    lat_on = 1'b0;

    wait (g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
